// File: rtl/writeback_queue_if.sv
// Producer-side handshakes (ALU and load path) plus the register file write port
// for writeback_queue. The queue is the slave; producers and the regfile side are the master.
interface writeback_queue_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     alu_valid;
  logic [ADDRESS_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     alu_ready;
  logic                     mem_valid;
  logic [ADDRESS_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0]    mem_data;
  logic                     mem_ready;
  logic                     hold;
  logic                     WE3;
  logic [ADDRESS_WIDTH-1:0] AD3;
  logic [DATA_WIDTH-1:0]    WD3;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, hold,
    output alu_ready, mem_ready, WE3, AD3, WD3
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, hold,
    input  alu_ready, mem_ready, WE3, AD3, WD3
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO between the ALU/load paths and register file port 3.
// Define WRITEBACK_BYPASS_EN to build the youngest-match bypass lookup for two read ports.
module writeback_queue #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  writeback_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic [ADDRESS_WIDTH-1:0] q1_addr,
  input  logic [ADDRESS_WIDTH-1:0] q2_addr,
  output logic                     q1_hit,
  output logic                     q2_hit,
  output logic [DATA_WIDTH-1:0]    q1_data,
  output logic [DATA_WIDTH-1:0]    q2_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic                     mem_fire, alu_fire, push, pop;
  logic [ADDRESS_WIDTH-1:0] in_rd;
  logic [DATA_WIDTH-1:0]    in_data;

  assign count = count_reg;
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // Load path has fixed priority; alu_ready deliberately ignores alu_valid.
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;

  assign mem_fire = bus.mem_valid && bus.mem_ready;
  assign alu_fire = bus.alu_valid && bus.alu_ready;
  assign in_rd    = mem_fire ? bus.mem_rd   : bus.alu_rd;
  assign in_data  = mem_fire ? bus.mem_data : bus.alu_data;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign push = (mem_fire || alu_fire) && (in_rd != '0);
  assign pop  = !empty && !bus.hold;

  assign bus.WE3 = pop;
  assign bus.AD3 = empty ? '0 : rd_mem[head_reg];
  assign bus.WD3 = empty ? '0 : data_mem[head_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage is intentionally not reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg]   <= in_rd;
      data_mem[tail_reg] <= in_data;
    end
  end

`ifdef WRITEBACK_BYPASS_EN
  for (genvar gi = 0; gi < 2; gi++) begin : gen_query
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     hit_c;
    logic [DATA_WIDTH-1:0]    data_c;
    logic [PTR_W-1:0]         idx;

    assign addr = (gi == 0) ? q1_addr : q2_addr;

    // Walk oldest to youngest so the last match is the youngest pending write.
    always_comb begin
      hit_c  = 1'b0;
      data_c = '0;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_reg + PTR_W'(i);
        if ((CNT_W'(i) < count_reg) && (rd_mem[idx] == addr)) begin
          hit_c  = 1'b1;
          data_c = data_mem[idx];
        end
      end
      if (addr == '0) begin
        hit_c  = 1'b0;
        data_c = '0;
      end
    end
  end

  assign q1_hit  = gen_query[0].hit_c;
  assign q1_data = gen_query[0].data_c;
  assign q2_hit  = gen_query[1].hit_c;
  assign q2_data = gen_query[1].data_c;
`else
  logic unused_query;
  assign unused_query = ^{q1_addr, q2_addr};
  assign q1_hit  = 1'b0;
  assign q2_hit  = 1'b0;
  assign q1_data = '0;
  assign q2_data = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_queue;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_queue_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  logic [2:0]    count;
  logic          full, empty;
  logic [AW-1:0] q1_addr, q2_addr;
  logic          q1_hit, q2_hit;
  logic [DW-1:0] q1_data, q2_data;

  writeback_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .count(count), .full(full), .empty(empty),
    .q1_addr(q1_addr), .q2_addr(q2_addr),
    .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_data(q1_data), .q2_data(q2_data)
  );

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] m_rd   [$];
  logic [DW-1:0] m_data [$];

`ifdef WRITEBACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_query(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (BYP && a != '0) begin
      for (int i = m_rd.size() - 1; i >= 0; i--) begin
        if (m_rd[i] == a) begin
          hit = 1'b1;
          d   = m_data[i];
          break;
        end
      end
    end
  endfunction

  task automatic compare();
    int n;
    logic e_full, h1, h2;
    logic [DW-1:0] d1, d2;
    n = m_rd.size();
    e_full = (n == DEPTH);
    model_query(q1_addr, h1, d1);
    model_query(q2_addr, h2, d2);
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(e_full));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("mem_ready", 64'(bus.mem_ready), 64'(!e_full));
    chk("alu_ready", 64'(bus.alu_ready), 64'(!e_full && !bus.mem_valid));
    chk("WE3", 64'(bus.WE3), 64'(n > 0 && !bus.hold));
    chk("AD3", 64'(bus.AD3), (n > 0) ? 64'(m_rd[0]) : 64'd0);
    chk("WD3", 64'(bus.WD3), (n > 0) ? 64'(m_data[0]) : 64'd0);
    chk("q1_hit", 64'(q1_hit), 64'(h1));
    chk("q1_data", 64'(q1_data), 64'(d1));
    chk("q2_hit", 64'(q2_hit), 64'(h2));
    chk("q2_data", 64'(q2_data), 64'(d2));
  endtask

  // One clock: check at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    logic          do_push, do_pop, is_full;
    logic [AW-1:0] p_rd;
    logic [DW-1:0] p_data;
    @(negedge clk);
    compare();
    is_full = (m_rd.size() == DEPTH);
    do_push = 1'b0;
    p_rd    = '0;
    p_data  = '0;
    if (bus.mem_valid && !is_full) begin
      do_push = (bus.mem_rd != '0);
      p_rd = bus.mem_rd;
      p_data = bus.mem_data;
    end else if (bus.alu_valid && !is_full && !bus.mem_valid) begin
      do_push = (bus.alu_rd != '0);
      p_rd = bus.alu_rd;
      p_data = bus.alu_data;
    end
    do_pop = (m_rd.size() > 0) && !bus.hold;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (do_pop) begin
        void'(m_rd.pop_front());
        void'(m_data.pop_front());
      end
      if (do_push) begin
        m_rd.push_back(p_rd);
        m_data.push_back(p_data);
      end
    end
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                       input logic h, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
    bus.hold      = h;
    q1_addr       = a1;
    q2_addr       = a2;
  endtask

  task automatic idle(input logic h);
    drive(1'b0, '0, '0, 1'b0, '0, '0, h, '0, '0);
  endtask

  initial begin
    idle(1'b0);
    #1;
    chk("rst_WE3", 64'(bus.WE3), 64'd0);
    chk("rst_AD3", 64'(bus.AD3), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    chk("rst_q1_hit", 64'(q1_hit), 64'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Single ALU transfer
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle();
    idle(1'b0);
    #1;
    chk("t1_WE3", 64'(bus.WE3), 64'd1);
    chk("t1_AD3", 64'(bus.AD3), 64'd5);
    chk("t1_WD3", 64'(bus.WD3), 64'hDEADBEEF);
    cycle();
    chk("t1_WE3_after", 64'(bus.WE3), 64'd0);
    chk("t1_empty", 64'(empty), 64'd1);

    // Mem beats ALU, ALU follows
    drive(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
    #1;
    chk("t2_mem_ready", 64'(bus.mem_ready), 64'd1);
    chk("t2_alu_ready", 64'(bus.alu_ready), 64'd0);
    cycle();
    drive(1'b1, 5'd4, 32'h22, 1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("t2_AD3_mem", 64'(bus.AD3), 64'd3);
    chk("t2_WD3_mem", 64'(bus.WD3), 64'h11);
    cycle();
    idle(1'b0);
    #1;
    chk("t2_AD3_alu", 64'(bus.AD3), 64'd4);
    chk("t2_WD3_alu", 64'(bus.WD3), 64'h22);
    cycle();

    // Fill under hold, offer into a full queue, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), 32'h100 + i, 1'b0, '0, '0, 1'b1, '0, '0);
      cycle();
    end
    drive(1'b1, 5'd9, 32'h999, 1'b0, '0, '0, 1'b1, '0, '0);
    #1;
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_alu_ready", 64'(bus.alu_ready), 64'd0);
    cycle();
    for (int i = 1; i <= 4; i++) begin
      idle(1'b0);
      #1;
      chk("t3_drain_AD3", 64'(bus.AD3), 64'(i));
      cycle();
    end
    chk("t3_empty", 64'(empty), 64'd1);

    // x0 transfer is acknowledged and dropped
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
    cycle();
    idle(1'b0);
    #1;
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_WE3", 64'(bus.WE3), 64'd0);
    cycle();

    // Bypass youngest match
    drive(1'b1, 5'd7, 32'hA, 1'b0, '0, '0, 1'b1, '0, '0);
    cycle();
    drive(1'b1, 5'd7, 32'hB, 1'b0, '0, '0, 1'b1, 5'd7, 5'd0);
    #1;
    chk("t5_q1_hit_before", 64'(q1_hit), 64'(BYP));
    chk("t5_q1_data_before", 64'(q1_data), BYP ? 64'hA : 64'd0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd0);
    #1;
    chk("t5_q1_hit", 64'(q1_hit), 64'(BYP));
    chk("t5_q1_data", 64'(q1_data), BYP ? 64'hB : 64'd0);
    chk("t5_q2_hit", 64'(q2_hit), 64'd0);
    chk("t5_q2_data", 64'(q2_data), 64'd0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      cycle();
    end

    // Asynchronous reset with pending entries
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, AW'(i), 32'h300 + i, 1'b0, '0, '0, 1'b1, '0, '0);
      cycle();
    end
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_WE3", 64'(bus.WE3), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    m_rd.delete();
    m_data.delete();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
